crc_frame_serializer: RTL and testbench

- Upstream stage for the serial CRC-32 generator. Accepts a framed byte stream over a valid/ready handshake and drives the generator's new_message, enable and data_in pins.
- Serializes each byte LSB-first, one bit per enabled cycle.
- At end of frame, waits for the generator to settle, captures its 32-bit result and presents it with a one-cycle valid strobe to downstream framing logic.

---
 rtl/crc_frame_serializer_pkg.sv | 15 +
 rtl/crc_byte_hold.sv | 37 +++
 rtl/crc_frame_serializer.sv | 125 ++++++++++++
 tb/tb_crc_frame_serializer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/crc_frame_serializer_pkg.sv
// Shared types and constants for the CRC-32 frame serializer and its helpers.
package crc_pkg;
  localparam int CRC_W  = 32;
  localparam int BYTE_W = 8;
  localparam logic [CRC_W-1:0] CRC32_CHECK_VALUE = 32'hCBF43926;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    SHIFT  = 3'd2,
    GAP    = 3'd3,
    SETTLE = 3'd4,
    DONE   = 3'd5
  } state_e;
endpackage

// File: rtl/crc_byte_hold.sv
// One-entry hold register with valid/ready on the input and a drain strobe on the output.
module crc_byte_hold #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_drain,
  output logic         o_full,
  output logic [W-1:0] o_data
);
  logic         r_full;
  logic [W-1:0] r_data;
  logic         w_load;

  // Ready is held low during reset so every output reads 0 while rst is high.
  assign o_ready = !r_full && !rst;
  assign w_load  = i_valid && o_ready;
  assign o_full  = r_full;
  assign o_data  = r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else begin
      if (w_load) begin
        r_data <= i_data;
        r_full <= 1'b1;
      end else if (i_drain) begin
        r_full <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/crc_frame_serializer.sv
// Serializes a framed byte stream into a serial CRC-32 generator and captures the result.
// Define CRC_FRAME_SERIALIZER_MSB_FIRST_EN to shift bytes out MSB-first instead of LSB-first.
import crc_pkg::*;

module crc_frame_serializer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BYTE_W-1:0] s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic             crc_new_message,
  output logic             crc_enable,
  output logic             crc_data,
  input  logic [CRC_W-1:0] crc_in,
  output logic [CRC_W-1:0] frame_crc,
  output logic             frame_crc_valid,
  output logic [CNT_W-1:0] frame_bytes,
  output logic             busy
);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_e              r_state;
  logic [BYTE_W-1:0]   r_shift;
  logic                r_cur_last;
  logic [2:0]          r_bit;
  logic [CNT_W-1:0]    r_bytes;
  logic [SW-1:0]       r_settle;
  logic [CRC_W-1:0]    r_frame_crc;
  logic [CNT_W-1:0]    r_frame_bytes;

  logic                w_hold_full;
  logic [BYTE_W:0]     w_hold_q;
  logic                w_drain;
  logic                w_bit_last;
  logic                w_tx_bit;
  logic [BYTE_W-1:0]   w_shift_nxt;

  crc_byte_hold #(.W(BYTE_W + 1)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .i_data  ({s_last, s_data}),
    .i_valid (s_valid),
    .o_ready (s_ready),
    .i_drain (w_drain),
    .o_full  (w_hold_full),
    .o_data  (w_hold_q)
  );

`ifdef CRC_FRAME_SERIALIZER_MSB_FIRST_EN
  assign w_tx_bit    = r_shift[BYTE_W-1];
  assign w_shift_nxt = {r_shift[BYTE_W-2:0], 1'b0};
`else
  assign w_tx_bit    = r_shift[0];
  assign w_shift_nxt = {1'b0, r_shift[BYTE_W-1:1]};
`endif

  assign w_bit_last = (r_bit == 3'd7);
  // Hold drains whenever a byte moves into the shift register; next-frame bytes wait for DONE.
  assign w_drain = (r_state == START) ||
                   (r_state == GAP && w_hold_full) ||
                   (r_state == SHIFT && w_bit_last && !r_cur_last && w_hold_full);

  assign crc_new_message = (r_state == START);
  assign crc_enable      = (r_state == SHIFT);
  assign crc_data        = (r_state == SHIFT) && w_tx_bit;
  assign frame_crc_valid = (r_state == DONE);
  assign frame_crc       = r_frame_crc;
  assign frame_bytes     = r_frame_bytes;
  assign busy            = (r_state != DONE) && ((r_state != IDLE) || w_hold_full);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_shift       <= '0;
      r_cur_last    <= 1'b0;
      r_bit         <= '0;
      r_bytes       <= '0;
      r_settle      <= '0;
      r_frame_crc   <= '0;
      r_frame_bytes <= '0;
    end else begin
      if (w_drain) begin
        r_shift    <= w_hold_q[BYTE_W-1:0];
        r_cur_last <= w_hold_q[BYTE_W];
        r_bit      <= '0;
      end else if (r_state == SHIFT) begin
        r_shift <= w_shift_nxt;
        r_bit   <= r_bit + 3'd1;
      end

      case (r_state)
        IDLE:  if (w_hold_full) r_state <= START;
        START: begin
          r_bytes <= '0;
          r_state <= SHIFT;
        end
        SHIFT: if (w_bit_last) begin
          if (r_bytes != {CNT_W{1'b1}}) r_bytes <= r_bytes + CNT_W'(1);
          if (r_cur_last) begin
            r_settle <= '0;
            r_state  <= SETTLE;
          end else if (!w_hold_full) begin
            r_state <= GAP;
          end
        end
        GAP:   if (w_hold_full) r_state <= SHIFT;
        SETTLE: begin
          if (r_settle == SW'(SETTLE_CYCLES - 1)) begin
            r_frame_crc   <= crc_in;
            r_frame_bytes <= r_bytes;
            r_state       <= DONE;
          end else begin
            r_settle <= r_settle + SW'(1);
          end
        end
        DONE:    r_state <= w_hold_full ? START : IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crc_frame_serializer.sv
// Directed bench: serializer driving a behavioural reflected CRC-32 generator.
module tb_crc_frame_serializer;
  import crc_pkg::*;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       s_data = '0;
  logic             s_valid = 1'b0;
  logic             s_last = 1'b0;
  logic             s_ready;
  logic             crc_new_message, crc_enable, crc_data;
  logic [31:0]      crc_in;
  logic [31:0]      frame_crc;
  logic             frame_crc_valid;
  logic [CNT_W-1:0] frame_bytes;
  logic             busy;

  always #5 clk = ~clk;

  crc_frame_serializer #(.SETTLE_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .crc_new_message(crc_new_message), .crc_enable(crc_enable),
    .crc_data(crc_data), .crc_in(crc_in), .frame_crc(frame_crc),
    .frame_crc_valid(frame_crc_valid), .frame_bytes(frame_bytes), .busy(busy)
  );

  // Serial reflected CRC-32 generator: registered state, inverted output.
  logic [31:0] g_state;
  always @(posedge clk) begin
    if (rst || crc_new_message) g_state <= 32'hFFFFFFFF;
    else if (crc_enable)
      g_state <= (g_state >> 1) ^ ((g_state[0] ^ crc_data) ? 32'hEDB88320 : 32'h0);
  end
  assign crc_in = ~g_state;

  int compared = 0, mismatched = 0;
  logic [31:0] sq_crc[$];
  int sq_bytes[$], sq_low[$], sq_lat[$], run_q[$];
  int run = 0, en_total = 0, cyc = 0, t_nm = 0, t_en = 0, t_last_en = 0;
  int overlap = 0, data_off = 0, low_total = 0;
  bit armed = 0;

  always @(negedge clk) begin
    cyc++;
    if (crc_enable) begin run++; en_total++; t_last_en = cyc; end
    else if (run != 0) begin run_q.push_back(run); run = 0; end
    if (crc_new_message) begin t_nm = cyc; armed = 1; end
    if (crc_enable && armed) begin t_en = cyc; armed = 0; end
    if (crc_new_message && crc_enable) overlap++;
    if (!crc_enable && crc_data) data_off++;
    if (!rst && !busy && !frame_crc_valid && s_valid) low_total++;
    if (frame_crc_valid) begin
      sq_crc.push_back(frame_crc);
      sq_bytes.push_back(int'(frame_bytes));
      sq_low.push_back(low_total);
      sq_lat.push_back(cyc - t_last_en);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input bit l);
    int n = 0;
    s_data = d; s_last = l; s_valid = 1'b1;
    while (!s_ready && n < 1000) begin @(negedge clk); n++; end
    if (!s_ready) begin
      compared++; mismatched++;
      $display("FAIL send_timeout: s_ready observed 0 expected 1");
    end
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0; s_data = 8'($urandom); s_last = 1'($urandom);
  endtask

  task automatic send_str(input string s, input int gapmax, input bit mark_last);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i], mark_last && (i == s.len() - 1));
      repeat ($urandom_range(gapmax, 0)) @(negedge clk);
    end
  endtask

  task automatic send_rep(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) send(d, i == n - 1);
  endtask

  task automatic wait_strobes(input int n);
    int k = 0;
    while (sq_crc.size() < n && k < 3000) begin @(negedge clk); k++; end
    if (sq_crc.size() < n) begin
      compared++; mismatched++;
      $display("FAIL strobe_timeout: strobes observed %0d expected %0d", sq_crc.size(), n);
      while (sq_crc.size() < n) begin
        sq_crc.push_back('0); sq_bytes.push_back(0); sq_low.push_back(0); sq_lat.push_back(0);
      end
    end
  endtask

  int b, rb, eb;
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {s_ready, crc_new_message, crc_enable, crc_data, frame_crc_valid,
                          busy, frame_crc, frame_bytes}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // "123456789" with s_valid held high
    b = sq_crc.size(); rb = run_q.size();
    send_str("123456789", 0, 1);
    wait_strobes(b + 1);
    chk("check_crc", sq_crc[b], CRC32_CHECK_VALUE);
    chk("check_bytes", sq_bytes[b], 9);
    chk("check_enable_runs", run_q.size() - rb, 1);
    chk("check_enable_len", run_q[rb], 72);
    chk("check_strobe_latency", sq_lat[b], 3);

    b = sq_crc.size();
    send_rep(8'h00, 4); wait_strobes(b + 1);
    chk("zeros4_crc", sq_crc[b], 32'h2144DF1C);
    chk("zeros4_bytes", sq_bytes[b], 4);
    send_rep(8'hFF, 4); wait_strobes(b + 2);
    chk("ones4_crc", sq_crc[b+1], 32'hFFFFFFFF);
    chk("ones4_bytes", sq_bytes[b+1], 4);
    send_rep(8'h55, 4); wait_strobes(b + 3);
    chk("x55_crc", sq_crc[b+2], 32'h6B2DC0BD);
    chk("x55_bytes", sq_bytes[b+2], 4);

    // Single-byte frame
    b = sq_crc.size();
    send_rep(8'h00, 1); wait_strobes(b + 1);
    chk("single_crc", sq_crc[b], 32'hD202EF8D);
    chk("single_bytes", sq_bytes[b], 1);
    chk("single_nm_to_en", t_en - t_nm, 1);

    // Random input gaps
    b = sq_crc.size(); eb = en_total;
    send_str("123456789", 5, 1);
    wait_strobes(b + 1);
    chk("gaps_crc", sq_crc[b], CRC32_CHECK_VALUE);
    chk("gaps_bytes", sq_bytes[b], 9);
    chk("gaps_enable_total", en_total - eb, 72);

    // Back-to-back frames
    b = sq_crc.size();
    send_str("123456789", 0, 1);
    send_rep(8'hAA, 4);
    wait_strobes(b + 2);
    chk("b2b_crc0", sq_crc[b], CRC32_CHECK_VALUE);
    chk("b2b_bytes0", sq_bytes[b], 9);
    chk("b2b_crc1", sq_crc[b+1], 32'hB596E05E);
    chk("b2b_bytes1", sq_bytes[b+1], 4);
    chk("b2b_busy_gap", sq_low[b+1] - sq_low[b], 0);

    // Reset mid-frame, then a fresh frame
    b = sq_crc.size();
    send_str("123", 0, 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_outputs", {s_ready, crc_new_message, crc_enable, crc_data, frame_crc_valid,
                           busy, frame_crc, frame_bytes}, 64'h0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("midrst_no_strobe", sq_crc.size() - b, 0);
    send_str("123456789", 0, 1);
    wait_strobes(b + 1);
    chk("midrst_fresh_crc", sq_crc[b], CRC32_CHECK_VALUE);
    chk("midrst_fresh_bytes", sq_bytes[b], 9);

    chk("nm_enable_overlap", overlap, 0);
    chk("data_while_disabled", data_off, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
